// File: rtl/aes_pkg.sv
// Shared AES types, round/key constants and GF(2^8) helper functions used by
// the iterative AES-128/192/256 core and its key schedule.
package aes_pkg;

  typedef enum logic [1:0] {
    KM_128  = 2'b00,
    KM_192  = 2'b01,
    KM_256  = 2'b10,
    KM_RSVD = 2'b11
  } key_mode_t;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Index 0 holds Rcon[1]; the key schedule counts mod-0 steps from zero.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0: r = 8'h01;  4'd1: r = 8'h02;  4'd2: r = 8'h04;  4'd3: r = 8'h08;
      4'd4: r = 8'h10;  4'd5: r = 8'h20;  4'd6: r = 8'h40;  4'd7: r = 8'h80;
      4'd8: r = 8'h1b;  4'd9: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // S-box computed as inverse (x^254 via a short addition chain) plus affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(b, b);
    x3   = gf_mul(x2, b);
    x12  = gf_mul(x3, x3);
    x12  = gf_mul(x12, x12);
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [3:0] nk_of(input key_mode_t m);
    case (m)
      KM_192:  return NK_192;
      KM_256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_keysched_iter.sv
// On-the-fly AES key expansion: an 8-word window w[4r-4..4r+3] that slides by
// four words per advance; the round key for round r is the upper half.
module aes_keysched_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         advance_i,
  input  key_mode_t    key_mode_i,
  input  logic [255:0] key_i,
  output logic [127:0] round_key_o
);

  logic [31:0] win_q [8];
  logic [31:0] win_d [8];
  logic [31:0] kw    [8];
  logic [31:0] src   [8];
  logic [31:0] gen   [4];
  logic [31:0] prev, tmp;
  logic [3:0]  nk_q, nk_c, pos_q, pos_c, rc_q, rc_c;
  logic [2:0]  idx;

  // On load the window is seeded as w[0..7]: words below Nk come straight from
  // the key, the rest are generated, so round 1 already sees w[4..7].
  always_comb begin
    for (int j = 0; j < 8; j++) kw[j] = key_i[255-32*j -: 32];
    nk_c = load_i ? nk_of(key_mode_i) : nk_q;
    pos_c = load_i ? ((nk_c == NK_128) ? 4'd0 : 4'd4) : pos_q;
    rc_c  = load_i ? 4'd0 : rc_q;
    for (int j = 0; j < 4; j++) begin
      src[j]   = load_i ? kw[4+j] : win_q[j];
      src[4+j] = load_i ? kw[j]   : win_q[4+j];
    end
    prev = src[7];
    tmp  = '0;
    idx  = '0;
    for (int j = 0; j < 4; j++) begin
      idx = 3'(8 + j - int'(nk_c));
      if (pos_c == 4'd0) begin
        tmp  = sub_word(rot_word(prev)) ^ {rcon(rc_c), 24'h0};
        rc_c = rc_c + 4'd1;
      end else if (nk_c == NK_256 && pos_c == 4'd4) begin
        tmp = sub_word(prev);
      end else begin
        tmp = prev;
      end
      gen[j] = (load_i && (4 + j) < int'(nk_c)) ? kw[4+j] : (src[idx] ^ tmp);
      prev   = gen[j];
      pos_c  = (pos_c + 4'd1 == nk_c) ? 4'd0 : pos_c + 4'd1;
    end
    for (int j = 0; j < 8; j++) win_d[j] = win_q[j];
    if (load_i) begin
      for (int j = 0; j < 4; j++) begin
        win_d[j]   = kw[j];
        win_d[4+j] = gen[j];
      end
    end else if (advance_i) begin
      for (int j = 0; j < 4; j++) begin
        win_d[j]   = win_q[4+j];
        win_d[4+j] = gen[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nk_q  <= NK_128;
      pos_q <= 4'd0;
      rc_q  <= 4'd0;
    end else if (load_i || advance_i) begin
      nk_q  <= nk_c;
      pos_q <= pos_c;
      rc_q  <= rc_c;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 8; j++) win_q[j] <= win_d[j];
  end

  assign round_key_o = {win_q[4], win_q[5], win_q[6], win_q[7]};

endmodule

// File: rtl/aes_core_kx.sv
// Iterative AES-128/192/256 encryption core, one round per clock, with
// valid/ready handshakes on both sides and optional back-to-back acceptance.
module aes_core_kx
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              key_mode,
  input  logic [MAX_KEY_BITS-1:0] key,
  input  logic [127:0]            plaintext,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            cyphertext,
  output logic                    mode_err,
  output logic                    busy
);

  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   round_q, round_d, nr_q, nr_d, nr_in;
  logic         err_q, err_d;
  logic [127:0] state_q, state_d;
  logic [255:0] key_pad;
  logic [127:0] round_key;
  logic         accept, mode_ok, ks_adv;

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] t, m;
    for (int b = 0; b < 16; b++) t[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
    t = shift_rows(t);
    m = t;
    if (!last)
      for (int c = 0; c < 4; c++) m[127-32*c -: 32] = mix_column(t[127-32*c -: 32]);
    return m ^ rk;
  endfunction

  always_comb begin
    key_pad = '0;
    key_pad[255 -: MAX_KEY_BITS] = key;
  end

  always_comb begin
    case (key_mode)
      KM_128:  begin mode_ok = 1'b1;                nr_in = NR_128; end
      KM_192:  begin mode_ok = (MAX_KEY_BITS >= 192); nr_in = NR_192; end
      KM_256:  begin mode_ok = (MAX_KEY_BITS >= 256); nr_in = NR_256; end
      default: begin mode_ok = 1'b0;                nr_in = NR_128; end
    endcase
  end

  // in_ready only looks through out_ready when a same-cycle hand-over is allowed.
  assign in_ready   = (fsm_q == ST_IDLE) ||
                      (BACK_TO_BACK && (fsm_q == ST_HOLD) && out_ready);
  assign out_valid  = (fsm_q == ST_HOLD);
  assign busy       = (fsm_q != ST_IDLE);
  assign mode_err   = out_valid && err_q;
  assign cyphertext = state_q;
  assign accept     = in_valid && in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    nr_d    = nr_q;
    err_d   = err_q;
    state_d = state_q;
    ks_adv  = 1'b0;
    case (fsm_q)
      ST_IDLE, ST_HOLD: begin
        if (fsm_q == ST_HOLD && out_ready) begin
          fsm_d   = ST_IDLE;
          round_d = 4'd0;
        end
        if (accept) begin
          fsm_d   = ST_ROUND;
          round_d = 4'd1;
          nr_d    = nr_in;
          err_d   = !mode_ok;
          state_d = plaintext ^ key_pad[255:128];
        end
      end
      ST_ROUND: begin
        if (err_q) begin
          fsm_d   = ST_HOLD;
          state_d = '0;
        end else begin
          state_d = aes_round(state_q, round_key, round_q == nr_q);
          if (round_q == nr_q) begin
            fsm_d = ST_HOLD;
          end else begin
            round_d = round_q + 4'd1;
            ks_adv  = 1'b1;
          end
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= ST_IDLE;
      round_q <= 4'd0;
      nr_q    <= NR_128;
      err_q   <= 1'b0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  aes_keysched_iter u_keysched (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .advance_i   (ks_adv),
    .key_mode_i  (key_mode_t'(key_mode)),
    .key_i       (key_pad),
    .round_key_o (round_key)
  );

endmodule

// File: tb/tb_aes_core_kx.sv
// Directed bench for aes_core_kx using FIPS-197 vectors, backpressure,
// back-to-back hand-over, reserved mode and mid-block reset.
module tb_aes_core_kx;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   key_mode = 2'b00;
  logic [255:0] key = '0;
  logic [127:0] plaintext = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] cyphertext;
  logic         mode_err;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128A = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K128B = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CT_C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_core_kx #(.MAX_KEY_BITS(256), .BACK_TO_BACK(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key_mode   (key_mode),
    .key        (key),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cyphertext (cyphertext),
    .mode_err   (mode_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a block (optionally acking the pending result) and let one edge accept it.
  task automatic present(input logic [1:0] m, input logic [255:0] k,
                         input logic [127:0] p, input logic ack);
    key_mode  = m;
    key       = k;
    plaintext = p;
    in_valid  = 1'b1;
    out_ready = ack;
    #1;
    chk("in_ready_at_offer", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
    for (int i = 0; i < 4; i++) plaintext[32*i +: 32] = $urandom;
    key_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic await_result(input string tag, input logic [127:0] exp,
                              input int lat, input logic err);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(lat));
    chk({tag, "_ct"}, cyphertext, exp);
    chk({tag, "_mode_err"}, mode_err, err);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_ack", out_valid, 0);
    chk("mode_err_after_ack", mode_err, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ct", cyphertext, 0);
    chk("rst_mode_err", mode_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    present(2'b00, K128A, PT_A, 1'b0);
    chk("busy_in_round", busy, 1);
    chk("in_ready_in_round", in_ready, 0);
    await_result("aes128_b", CT_A, 10, 1'b0);

    // Stall the result while the next block waits on the input side.
    key_mode = 2'b10; key = K256; plaintext = PT_C; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_ct", cyphertext, CT_A);
      chk("stall_in_ready", in_ready, 0);
    end

    present(2'b10, K256, PT_C, 1'b1);
    await_result("b2b_aes256", CT_C256, 14, 1'b0);
    present(2'b01, K192, PT_C, 1'b1);
    await_result("b2b_aes192", CT_C192, 12, 1'b0);
    present(2'b00, K128B, PT_C, 1'b1);
    await_result("b2b_aes128", CT_C128, 10, 1'b0);
    release_result();

    present(2'b11, K256, PT_A, 1'b0);
    await_result("rsvd_mode", 128'h0, 1, 1'b1);
    present(2'b00, K128A, PT_A, 1'b1);
    await_result("after_rsvd", CT_A, 10, 1'b0);
    release_result();

    present(2'b10, K256, PT_C, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_ct", cyphertext, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    present(2'b10, K256, PT_C, 1'b0);
    await_result("post_abort_aes256", CT_C256, 14, 1'b0);
    release_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
